mux4_rr_arbiter: RTL



---
 rtl/mux4_rr_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/mux4_rr_arbiter.sv
//==============================================================================
// Module   : mux4_rr_arbiter
// Brief    : Round-robin arbiter that owns the select of a shared 4:1 mux and
//            holds each grant until done, owner request drop, or hold timeout.
// Options  : `define ARB_TIMEOUT_EN enables the MAX_HOLD forced release.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module mux4_rr_arbiter #(
    parameter int MAX_HOLD  = 16,
    parameter int CNT_WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] select,
    output logic       busy,
    output logic       timeout
);

    localparam logic [0:0] c_st_idle  = 1'b0;
    localparam logic [0:0] c_st_grant = 1'b1;

    // Elaboration-time guard against an illegal hold configuration.
    generate
        if ((MAX_HOLD < 2) || (MAX_HOLD > 255) || ((64'd1 << CNT_WIDTH) <= 64'(MAX_HOLD))) begin : g_bad_cfg
            $error("mux4_rr_arbiter: illegal MAX_HOLD/CNT_WIDTH combination");
        end
    endgenerate

    logic [0:0]           r_state;
    logic [1:0]           r_ptr;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [3:0]           r_gnt;
    logic [1:0]           r_select;
    logic                 r_timeout;

    logic [0:0]           w_state_nxt;
    logic [1:0]           w_ptr_nxt;
    logic [CNT_WIDTH-1:0] w_cnt_nxt;
    logic [3:0]           w_gnt_nxt;
    logic [1:0]           w_select_nxt;
    logic                 w_timeout_nxt;

    logic                 w_idle_found;
    logic [1:0]           w_idle_win;
    logic                 w_hand_found;
    logic [1:0]           w_hand_win;
    logic [3:0]           w_others;
    logic                 w_owner_req;
    logic                 w_hold_hit;
    logic                 w_release;
    logic                 w_forced;

`ifdef ARB_TIMEOUT_EN
    localparam logic [CNT_WIDTH-1:0] c_hold_last = CNT_WIDTH'(MAX_HOLD - 1);
    assign w_hold_hit = (r_cnt == c_hold_last);
`else
    assign w_hold_hit = 1'b0;
`endif

    assign w_owner_req = req[r_select];
    assign w_others    = req & ~(4'b0001 << r_select);
    assign w_release   = done | ~w_owner_req | w_hold_hit;
    // A same-edge done or owner drop makes it an ordinary release, not a timeout.
    assign w_forced    = w_hold_hit & ~done & w_owner_req;

    // Scans run highest offset first so the nearest set bit is the last write.
    always_comb begin
        w_idle_found = 1'b0;
        w_idle_win   = r_ptr;
        for (int k = 3; k >= 0; k--) begin
            if (req[r_ptr + 2'(k)]) begin
                w_idle_found = 1'b1;
                w_idle_win   = r_ptr + 2'(k);
            end
        end
    end

    always_comb begin
        w_hand_found = 1'b0;
        w_hand_win   = r_select;
        for (int k = 3; k >= 1; k--) begin
            if (w_others[r_select + 2'(k)]) begin
                w_hand_found = 1'b1;
                w_hand_win   = r_select + 2'(k);
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_cnt_nxt     = r_cnt;
        w_gnt_nxt     = r_gnt;
        w_select_nxt  = r_select;
        w_timeout_nxt = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (w_idle_found) begin
                    w_state_nxt  = c_st_grant;
                    w_gnt_nxt    = 4'b0001 << w_idle_win;
                    w_select_nxt = w_idle_win;
                    w_cnt_nxt    = '0;
                end
            end
            c_st_grant: begin
                if (w_release) begin
                    w_ptr_nxt     = r_select + 2'd1;
                    w_timeout_nxt = w_forced;
                    w_cnt_nxt     = '0;
                    if (w_hand_found) begin
                        w_gnt_nxt    = 4'b0001 << w_hand_win;
                        w_select_nxt = w_hand_win;
                    end else begin
                        w_state_nxt = c_st_idle;
                        w_gnt_nxt   = 4'b0000;
                    end
                end else if (r_cnt != {CNT_WIDTH{1'b1}}) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
                w_gnt_nxt   = 4'b0000;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_st_idle;
            r_ptr     <= 2'd0;
            r_cnt     <= '0;
            r_gnt     <= 4'b0000;
            r_select  <= 2'd0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_cnt     <= w_cnt_nxt;
            r_gnt     <= w_gnt_nxt;
            r_select  <= w_select_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    assign gnt     = r_gnt;
    assign select  = r_select;
    assign busy    = |r_gnt;
    assign timeout = r_timeout;

endmodule

`default_nettype wire
